// File: rtl/ethhelper_arb_pkg.sv
// Shared types for the stream arbiter: FSM state, source index, round-robin step.
// Pure declarations; no timing or flow-control behaviour of its own.
package ethhelper_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  // Wide enough for the largest supported requester count (16).
  localparam int SRC_IDX_W = 4;
  typedef logic [SRC_IDX_W-1:0] src_idx_t;

  function automatic int rr_next(input int idx, input int num_req);
    return (idx + 1 >= num_req) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ethhelper_rr_pick.sv
// Rotating-priority picker: first set request after rr_ptr, wrapping around.
// Purely combinational; no flow control.
module ethhelper_rr_pick
  import ethhelper_arb_pkg::*;
#(
  parameter int NUM_REQ = 5
) (
  input  logic [NUM_REQ-1:0] req,
  input  src_idx_t           rr_ptr,
  output logic               found,
  output src_idx_t           idx
);

  always_comb begin
    int c;
    found = 1'b0;
    idx   = '0;
    c     = int'(rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      c = rr_next(c, NUM_REQ);
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = src_idx_t'(c);
      end
    end
  end

endmodule

// File: rtl/ethhelper_stream_arbiter.sv
// Packet-granular round-robin arbiter onto one registered AXI-Stream output.
// Grant one cycle after request, beat out one cycle after accept; ready stalls on full output slot.
module ethhelper_stream_arbiter
  import ethhelper_arb_pkg::*;
#(
  parameter  int NUM_REQ    = 5,
  parameter  int DATA_WIDTH = 128,
  parameter  int TIMEOUT    = 1024,
  localparam int SRC_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_in_progress,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [SRC_W-1:0]              m_axis_tid,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          busy,
  output logic                          err_timeout,
  input  logic                          err_clear
);

  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  arb_state_t            state, state_nxt;
  src_idx_t              grant_idx, rr_ptr, pick_idx;
  logic                  pick_found;
  logic [WD_W-1:0]       wd_cnt;
  logic [DATA_WIDTH-1:0] beat [NUM_REQ];
  logic                  out_free, accept, stall, wd_fire, pkt_end;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign beat[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  ethhelper_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req    (req_valid),
    .rr_ptr (rr_ptr),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Output slot is free when empty or draining this cycle.
  assign out_free = !m_axis_tvalid || m_axis_tready;
  assign accept   = (state == GRANT) && out_free && req_valid[grant_idx];
  assign stall    = (state == GRANT) && out_free && !req_valid[grant_idx];
  assign pkt_end  = accept && !req_in_progress[grant_idx];
  assign wd_fire  = (TIMEOUT != 0) && stall && (wd_cnt == WD_LAST);
  assign busy     = (state == GRANT);

  always_comb begin
    req_ready = '0;
    if (state == GRANT && out_free) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = GRANT;
      GRANT:   if (pkt_end || wd_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      grant_idx   <= '0;
      rr_ptr      <= src_idx_t'(NUM_REQ - 1);
      wd_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      if (state == IDLE && pick_found) grant_idx <= pick_idx;
      if (pkt_end || wd_fire) rr_ptr <= grant_idx;
      // Only requester-side starvation counts; downstream backpressure never does.
      if (state == IDLE || accept) wd_cnt <= '0;
      else if (stall)              wd_cnt <= wd_cnt + WD_W'(1);
      if (wd_fire)        err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tid    <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (accept) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= beat[grant_idx];
      m_axis_tid    <= grant_idx[SRC_W-1:0];
      m_axis_tlast  <= !req_in_progress[grant_idx];
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule
